digit_ram_rd_arbiter: RTL

//  Shares the single read port of the result-digit RAM (sum RAM, N-bit digits) between two

---
 rtl/controll_pkg.sv | 32 +++
 rtl/rd_tag_pipe.sv | 40 ++++
 rtl/digit_ram_rd_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/controll_pkg.sv
`default_nettype none
// ============================================================================
// Package : controll_pkg
// Brief   : Shared sizes and types for the result-digit RAM read arbiter.
// Revision: 1.0
// ============================================================================
package controll_pkg;

  localparam int ADR_BITS = 6;
  localparam int N        = 10;
  localparam int RAMDELAY = 2;
  localparam int L        = 50;
  localparam int MAX_WAIT = 8;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic   valid;
    owner_t port;
  } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module  : rd_tag_pipe
// Brief   : Shift pipe of {valid,port} tags matching the RAM read latency.
// Revision: 1.0
// ============================================================================
module rd_tag_pipe
  import controll_pkg::*;
#(
  parameter int DEPTH = RAMDELAY
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_head,
  output logic    empty
);

  rd_tag_t r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign tag_head = r_pipe[DEPTH-1];

  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_pipe[i].valid) empty = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/digit_ram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : digit_ram_rd_arbiter
// Brief   : Two-port read arbiter for the result-digit RAM, with in-flight
//           tag tracking. Define ARB_RR_EN for round-robin arbitration.
// Revision: 1.0
// ============================================================================
module digit_ram_rd_arbiter #(
  parameter int ADR_BITS = controll_pkg::ADR_BITS,
  parameter int N        = controll_pkg::N,
  parameter int RAMDELAY = controll_pkg::RAMDELAY,
  parameter int MAX_WAIT = controll_pkg::MAX_WAIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                calc_done,
  output logic [ADR_BITS-1:0] ram_rdadd,
  input  logic [N-1:0]        ram_q,
  input  logic                r0_req,
  input  logic [ADR_BITS-1:0] r0_addr,
  output logic                r0_gnt,
  output logic                r0_valid,
  output logic [N-1:0]        r0_data,
  input  logic                r1_req,
  input  logic [ADR_BITS-1:0] r1_addr,
  output logic                r1_gnt,
  output logic                r1_valid,
  output logic [N-1:0]        r1_data
);
  import controll_pkg::*;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  arb_state_t          r_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [ADR_BITS-1:0] r_last_addr;
  logic                w_open;
  logic                w_starved;
  logic                w_pick1;
  logic                w_gnt_any;
  logic                w_pipe_empty;
  logic                w_ret0;
  logic                w_ret1;
  rd_tag_t             w_tag_in;
  rd_tag_t             w_tag_head;

  // calc_done is also checked directly so the RAM is never touched once released
  assign w_open    = (r_state == ACTIVE) && calc_done && !rst;
  assign w_starved = (r_wait_cnt == WAIT_W'(MAX_WAIT));

`ifdef ARB_RR_EN
  logic r_favour1;

  always_ff @(posedge clk) begin
    if (rst)            r_favour1 <= 1'b0;
    else if (w_gnt_any) r_favour1 <= r0_gnt;
  end

  assign w_pick1 = r1_req && (!r0_req || r_favour1 || w_starved);
`else
  assign w_pick1 = r1_req && (!r0_req || w_starved);
`endif

  assign r1_gnt    = w_open && w_pick1;
  assign r0_gnt    = w_open && r0_req && !w_pick1;
  assign w_gnt_any = r0_gnt || r1_gnt;
  assign ram_rdadd = r1_gnt ? r1_addr : (r0_gnt ? r0_addr : r_last_addr);

  assign w_tag_in.valid = w_gnt_any;
  assign w_tag_in.port  = r1_gnt ? PORT1 : PORT0;

  rd_tag_pipe #(
    .DEPTH (RAMDELAY)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .tag_in   (w_tag_in),
    .tag_head (w_tag_head),
    .empty    (w_pipe_empty)
  );

  assign w_ret0 = w_tag_head.valid && (w_tag_head.port == PORT0);
  assign w_ret1 = w_tag_head.valid && (w_tag_head.port == PORT1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOCKED;
      r_wait_cnt  <= '0;
      r_last_addr <= '0;
      r0_valid    <= 1'b0;
      r1_valid    <= 1'b0;
      r0_data     <= '0;
      r1_data     <= '0;
    end else begin
      case (r_state)
        LOCKED:  if (calc_done)    r_state <= ACTIVE;
        ACTIVE:  if (!calc_done)   r_state <= DRAIN;
        DRAIN:   if (w_pipe_empty) r_state <= LOCKED;
        default:                   r_state <= LOCKED;
      endcase

      if (!r1_req || r1_gnt)           r_wait_cnt <= '0;
      else if (w_open && !w_starved)   r_wait_cnt <= r_wait_cnt + WAIT_W'(1);

      if (w_gnt_any) r_last_addr <= ram_rdadd;

      r0_valid <= w_ret0;
      r1_valid <= w_ret1;
      if (w_ret0) r0_data <= ram_q;
      if (w_ret1) r1_data <= ram_q;
    end
  end

endmodule
`default_nettype wire
